sr_pulse_gen: RTL

// - Upstream driver for SR_latch_dataflow: turns asynchronous set/reset requests into clean S/R pulses.
// - Each pulse is clocked, mutually exclusive and of guaranteed minimum width, so the NOR latch never sees S=R=1.
// - A guard gap follows every pulse. Output expected_q mirrors the latch state for checkers and readback.

---
 rtl/sr_pulse_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen - turns asynchronous set/reset requests into clean, clocked,
// mutually exclusive S/R pulses for a downstream NOR SR latch.
//
// Each request passes a 2-flop synchronizer, an optional debouncer and a
// registered rising-edge detector that produces a 1-cycle strobe. A small FSM
// (idle -> pulse -> gap) drives S or R for PULSE_CYC cycles, then forces
// GAP_CYC idle cycles. Strobes arriving while busy are held in a 1-deep,
// last-wins pending register.
//
// Optional feature macro: SR_PULSE_DEBOUNCE_EN
//   When defined, each synchronized request is debounced. Its level changes
//   only after DEB_CYC consecutive identical samples.
//
// Parameters:
//   PULSE_CYC  S/R pulse width in clk cycles (>= 1)
//   GAP_CYC    forced idle cycles after each pulse (>= 1)
//   DEB_CYC    stable-sample count for the debouncer
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   set_req     raw set request, asynchronous; rising edge = request
//   rst_req     raw reset request, asynchronous; rising edge = request
//   S           latch set drive, registered
//   R           latch reset drive, registered
//   busy        high while in the pulse or gap state
//   expected_q  model of latch Q after the last completed pulse

module sr_pulse_gen #(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned DEB_CYC   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic S,
    output logic R,
    output logic busy,
    output logic expected_q
);

    localparam int unsigned MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_PG > DEB_CYC) ? MAX_PG : DEB_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {st_idle, st_pulse, st_gap} state_t;
    typedef enum logic [1:0] {pend_none, pend_set, pend_rst} pend_t;

    // Bit 0 = set path, bit 1 = reset path.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] req_lvl;
    logic [1:0] lvl_prev_q;
    logic [1:0] stb_q;

    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_rst_q, op_rst_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             exp_q, exp_d;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {rst_req, set_req};
            sync2_q <= sync1_q;
        end
    end

`ifdef SR_PULSE_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debouncer: count consecutive samples that disagree with the current
    // level; flip the level once DEB_CYC of them have been seen in a row.
    // ------------------------------------------------------------------
    logic [1:0]       deb_lvl_q;
    logic [CNT_W-1:0] deb_cnt_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl_q    <= 2'b00;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_lvl_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == CNT_W'(DEB_CYC - 1)) begin
                    deb_lvl_q[i] <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign req_lvl = deb_lvl_q;
`else
    assign req_lvl = sync2_q;
`endif

    // ------------------------------------------------------------------
    // Registered rising-edge detectors -> 1-cycle strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev_q <= 2'b00;
            stb_q      <= 2'b00;
        end else begin
            lvl_prev_q <= req_lvl;
            stb_q      <= req_lvl & ~lvl_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Pulse FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= st_idle;
            pend_q   <= pend_none;
            cnt_q    <= '0;
            op_rst_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            op_rst_q <= op_rst_d;
            s_q      <= s_d;
            r_q      <= r_d;
            exp_q    <= exp_d;
        end
    end

    logic new_req;
    logic new_is_rst;
    logic start_rst;

    // Reset strobe beats a same-cycle set strobe.
    assign new_req    = stb_q[0] | stb_q[1];
    assign new_is_rst = stb_q[1];

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        op_rst_d  = op_rst_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        exp_d     = exp_q;
        start_rst = 1'b0;

        unique case (state_q)
            st_idle: begin
                if (new_req || (pend_q != pend_none)) begin
                    // A fresh strobe is newer than anything pending (last wins).
                    start_rst = new_req ? new_is_rst : (pend_q == pend_rst);
                    op_rst_d  = start_rst;
                    pend_d    = pend_none;
                    state_d   = st_pulse;
                    cnt_d     = CNT_W'(PULSE_CYC - 1);
                    s_d       = ~start_rst;
                    r_d       = start_rst;
                end
            end
            st_pulse: begin
                if (cnt_q == '0) begin
                    exp_d   = ~op_rst_q;
                    state_d = st_gap;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    s_d   = ~op_rst_q;
                    r_d   = op_rst_q;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            st_gap: begin
                if (cnt_q == '0) begin
                    state_d = st_idle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        // Capture requests that arrive while busy.
        if ((state_q != st_idle) && new_req) begin
            pend_d = new_is_rst ? pend_rst : pend_set;
        end
    end

    assign S          = s_q;
    assign R          = r_q;
    assign busy       = (state_q != st_idle);
    assign expected_q = exp_q;

endmodule
